// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA key-search scheduler and its helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package tea_pkg;

   localparam int          KEY_W    = 48;
   localparam logic [31:0] DELTA    = 32'h9E3779B9;
   localparam logic [31:0] SUM_INIT = 32'hC6EF3720;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } sched_state_t;

   typedef logic [KEY_W-1:0] key_t;

   // Number of set bits in a vector of up to 16 per-core flags.
   function automatic logic [4:0] popcnt16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'b0000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tea_prio_enc.sv
// Lowest-index-set priority encoder with an any-set flag.
// Latency: combinational.
// Backpressure: none.
// Ports: req (N request bits), idx (index of lowest set bit, 0 when none), any (some bit set).
module tea_prio_enc
   import tea_pkg::*;
#(
   parameter int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tea_key_sched.sv
// Sweeps [key_lo, key_hi] across N_CORES TEA cores; stops on the first valid plaintext.
// Latency: first core_start one cycle after the search enters RUN; done one cycle after DONE.
// Backpressure: a key is dispatched only to an idle core; ena low freezes every register.
// Ports: host side cmd_start/cmd_abort/key_lo/key_hi/data_in -> busy/done/found/aborted/
//        found_key/keys_tried; core side core_data/core_start/core_key -> core_rdy/core_valid/
//        core_key_out. Define TEA_SCHED_PERF_EN to add the cycle_cnt busy-cycle counter.
module tea_key_sched
   import tea_pkg::*;
#(
   parameter int N_CORES = 4,
   parameter int KEY_W   = tea_pkg::KEY_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     cmd_start,
   input  logic                     cmd_abort,
   input  logic [KEY_W-1:0]         key_lo,
   input  logic [KEY_W-1:0]         key_hi,
   input  logic [63:0]              data_in,
   output logic [63:0]              core_data,
   output logic [N_CORES-1:0]       core_start,
   output logic [N_CORES*KEY_W-1:0] core_key,
   input  logic [N_CORES-1:0]       core_rdy,
   input  logic [N_CORES-1:0]       core_valid,
   input  logic [N_CORES*KEY_W-1:0] core_key_out,
`ifdef TEA_SCHED_PERF_EN
   output logic [31:0]              cycle_cnt,
`endif
   output logic                     busy,
   output logic                     done,
   output logic                     found,
   output logic                     aborted,
   output logic [KEY_W-1:0]         found_key,
   output logic [KEY_W:0]           keys_tried
);

   localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   sched_state_t       state;
   logic [KEY_W:0]     next_key;   // one extra bit so an all-ones key_hi ends without wrapping
   logic [KEY_W-1:0]   last;
   logic [N_CORES-1:0] core_busy;

   logic [N_CORES-1:0] rdy_ok;
   logic [N_CORES-1:0] match_vec;
   logic [N_CORES-1:0] disp_vec;
   logic [N_CORES-1:0] busy_nxt;
   logic [IW-1:0]      idle_idx;
   logic [IW-1:0]      match_idx;
   logic               idle_any;
   logic               match_any;
   logic               match_take;
   logic               abort_take;
   logic               issued_all;
   logic               dispatch;
   logic [4:0]         n_rdy;

   // Results from cores we never started (or that were orphaned by reset) are dropped here.
   assign rdy_ok    = core_rdy & core_busy;
   assign match_vec = rdy_ok & core_valid;
   assign n_rdy     = popcnt16(16'(rdy_ok));

   tea_prio_enc #(.N(N_CORES)) u_idle_enc (
      .req (~core_busy),
      .idx (idle_idx),
      .any (idle_any)
   );

   tea_prio_enc #(.N(N_CORES)) u_match_enc (
      .req (match_vec),
      .idx (match_idx),
      .any (match_any)
   );

   // A match outranks an abort arriving in the same cycle; neither allows a dispatch.
   assign match_take = match_any && !found && (state == S_RUN || state == S_DRAIN);
   assign abort_take = cmd_abort && (state == S_RUN) && !match_take;
   assign issued_all = next_key > {1'b0, last};
   assign dispatch   = (state == S_RUN) && !issued_all && idle_any && !match_take && !abort_take;
   // Selection uses the registered busy bits, so a core freed this cycle is reused next cycle.
   assign disp_vec   = dispatch ? (N_CORES'(1) << idle_idx) : '0;
   assign busy_nxt   = (core_busy & ~rdy_ok) | disp_vec;

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         next_key   <= '0;
         last       <= '0;
         core_busy  <= '0;
         core_data  <= '0;
         core_start <= '0;
         core_key   <= '0;
         done       <= 1'b0;
         found      <= 1'b0;
         aborted    <= 1'b0;
         found_key  <= '0;
         keys_tried <= '0;
      end else if (ena) begin
         core_start <= disp_vec;
         core_busy  <= busy_nxt;
         done       <= 1'b0;
         keys_tried <= keys_tried + (KEY_W+1)'(n_rdy);
         if (dispatch) begin
            core_key[idle_idx*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
            next_key                          <= next_key + 1'b1;
         end
         if (match_take) begin
            found     <= 1'b1;
            found_key <= core_key_out[match_idx*KEY_W +: KEY_W];
         end
         case (state)
            S_IDLE: begin
               if (cmd_start) begin
                  core_data  <= data_in;
                  next_key   <= {1'b0, key_lo};
                  last       <= key_hi;
                  found      <= 1'b0;
                  aborted    <= 1'b0;
                  found_key  <= '0;
                  keys_tried <= '0;
                  state      <= (key_lo > key_hi) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (match_take || issued_all) begin
                  state <= S_DRAIN;
               end else if (abort_take) begin
                  aborted <= 1'b1;
                  state   <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (busy_nxt == '0) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef TEA_SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else if (ena) begin
         if (state == S_IDLE && cmd_start) begin
            cycle_cnt <= '0;
         end else if (busy && cycle_cnt != 32'hFFFF_FFFF) begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/tea_key_sched.md
Name: tea_key_sched

Overview:
- Key-search scheduler that shares one ciphertext block across N_CORES TEA decryption cores.
- Sweeps an inclusive 48-bit key range [key_lo, key_hi]:
  - hands a fresh key to each idle core;
  - collects per-core results;
  - stops on the first core reporting a valid plaintext.
- Sits between the host command interface and the core array. Cores are instantiated outside this block.

Parameters:
- N_CORES, 4, number of decryption cores driven (1..16).
- KEY_W, 48, width of the searched key field.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  global clock enable; all registers hold when low.
- cmd_start  in  1  one-cycle pulse; begins a search. Ignored unless the FSM is in IDLE.
- cmd_abort  in  1  stops dispatching; block drains and finishes with found=0.
- key_lo  in  KEY_W  first key, inclusive; sampled on cmd_start.
- key_hi  in  KEY_W  last key, inclusive; sampled on cmd_start.
- data_in  in  64  ciphertext; sampled on cmd_start.
- core_data  out  64  registered ciphertext, common to all cores.
- core_start  out  N_CORES  per-core one-cycle start pulse.
- core_key  out  N_CORES*KEY_W  per-core key; held from the start pulse until the core's result.
- core_rdy  in  N_CORES  per-core one-cycle pulse: result available.
- core_valid  in  N_CORES  per-core plaintext-match flag; qualified by core_rdy.
- core_key_out  in  N_CORES*KEY_W  key that produced the result; qualified by core_rdy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a search.
- found  out  1  search ended on a match; held until the next accepted cmd_start.
- aborted  out  1  search ended by cmd_abort; held like found.
- found_key  out  KEY_W  matching key; held like found.
- keys_tried  out  KEY_W+1  count of core results collected in the current search.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; per-core busy bits 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - on cmd_start, latch data_in into core_data, set next_key=key_lo, set last=key_hi;
  - clear found, aborted, found_key and keys_tried.
  - If key_lo > key_hi, go to DONE (zero keys tried). Otherwise go to RUN.
- RUN, dispatch:
  - at most one dispatch per cycle, to the lowest-index core whose busy bit is 0;
  - the dispatch drives core_key[i]=next_key, pulses core_start[i], sets busy[i], and increments next_key;
  - first dispatch occurs the cycle after entering RUN.
- next_key width: KEY_W+1 bits, so key_hi = 2^48-1 terminates without wrap.
- Issued-all condition: next_key > last. When it holds, stop dispatching and go to DRAIN.
- Collection, in any state:
  - core_rdy[i] clears busy[i] and increments keys_tried;
  - a core released in cycle t may be re-dispatched at the earliest in cycle t+1.
- Match handling:
  - core_rdy[i] & core_valid[i] while found=0 and state is RUN or DRAIN: set found=1, latch found_key=core_key_out[i], go to (or stay in) DRAIN;
  - simultaneous matches: lowest index wins;
  - later matches are counted but ignored.
- cmd_abort in RUN: set aborted=1 and go to DRAIN. Abort is ignored in IDLE/DONE. Abort has no effect if found is already set in the same cycle; found has priority.
- DRAIN: no dispatch. When all busy bits are 0, go to DONE.
- DONE: pulse done for one cycle, then go to IDLE.
- cmd_start while not in IDLE: ignored.
- core_rdy for a core whose busy bit is 0: ignored; not counted.
- rst mid-search: immediate return to reset values. Outstanding core results arriving afterwards are ignored, because busy=0.

Optional Feature:
- Macro TEA_SCHED_PERF_EN.
- Defined:
  - adds output cycle_cnt (32 bits), cleared on an accepted cmd_start;
  - increments on every ena cycle with busy=1;
  - saturates at 32'hFFFFFFFF; holds after done.
- Undefined: the port and counter do not exist.

Decomposition:
- Package tea_pkg, containing:
  - KEY_W;
  - DELTA = 32'h9E3779B9;
  - SUM_INIT = 32'hC6EF3720;
  - typedef sched_state_t for IDLE/RUN/DRAIN/DONE;
  - typedef key_t = logic [KEY_W-1:0].
- One sub-module, tea_prio_enc: N_CORES-bit lowest-index-set encoder with an any-set flag. Used twice: idle-core selection and match selection.

Test Plan:
- Full sweep, no match: N_CORES=4, key_lo=0x10, key_hi=0x1F, behavioural cores with 35-cycle latency and core_valid=0. Required: exactly 16 start pulses with keys 0x10..0x1F each once; keys_tried=16; done pulses once; found=0.
- Match: the core model sets valid for key 0x0000_0000_0017. Required: found=1, found_key=0x17. No dispatch after the match cycle. done only after every busy core returns.
- Simultaneous matches: cores 1 and 3 raise core_rdy&core_valid in the same cycle. Required: found_key equals core 1's key.
- Boundaries:
  - key_lo=key_hi=0xFFFF_FFFF_FFFF: exactly one dispatch, then done;
  - key_lo=5, key_hi=4: done within 2 cycles, keys_tried=0, no core_start.
- Abort then restart: cmd_abort 3 cycles after cmd_start. Required: aborted=1, found=0, done after drain. A new cmd_start afterwards clears aborted and sweeps correctly.
- rst mid-RUN with ena toggling: all outputs 0 immediately. Stale core_rdy pulses are not counted. With ena=0, state, counters and core_start do not advance.
